// File: rtl/usb_pkg.sv
// Shared USB link definitions: ULPI register map, widths and
// the register-arbiter state encoding.
package usb_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int ID_W   = 3;

  localparam logic [ADDR_W-1:0] ADDR_FUN_CTRL = 6'h04;
  localparam logic [ADDR_W-1:0] ADDR_OTG_CTRL = 6'h0A;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH  = 6'h16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } reg_txn_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request
// strictly after ptr, wrapping modulo N_REQ.
module rr_pick
  import usb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  int                s;
  logic [ID_W-1:0]   idx;
  logic [N_REQ-1:0]  r_sh;

  // Scan farthest-first so the closest hit is assigned last.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    s     = 0;
    idx   = '0;
    r_sh  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      s = int'(ptr) + i;
      if (s >= N_REQ) s = s - N_REQ;
      idx  = ID_W'(s);
      r_sh = req >> idx;
      if (r_sh[0]) begin
        id    = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ulpi_reg_arbiter.sv
// Round-robin arbiter sharing the ULPI PHY register port,
// one transaction in flight with a fixed wait timeout.
module ulpi_reg_arbiter
  import usb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                     CLK_60M,
  input  logic                     NRST_A_USB,
  input  logic [N_REQ-1:0]         REQ,
  input  logic [N_REQ-1:0]         REQ_RW,
  input  logic [ADDR_W*N_REQ-1:0]  REQ_ADDR,
  input  logic [DATA_W*N_REQ-1:0]  REQ_DATA,
  output logic [N_REQ-1:0]         ACK,
  output logic                     ACK_FAIL,
  output logic [DATA_W-1:0]        ACK_DATA,
  output logic                     BUSY,
  output logic [ID_W-1:0]          GRANT_ID,
  input  logic                     ULPI_READY,
  output logic                     ULPI_REG_EN,
  output logic                     ULPI_REG_RW,
  output logic [ADDR_W-1:0]        ULPI_REG_ADDR,
  output logic [DATA_W-1:0]        ULPI_REG_DATA_I,
  input  logic [DATA_W-1:0]        ULPI_REG_DATA_O,
  input  logic                     ULPI_REG_DONE,
  input  logic                     ULPI_REG_FAIL
);

  arb_state_e          state, state_nxt;
  reg_txn_t            txn_q, txn_sel;
  logic [ID_W-1:0]     ptr_q;
  logic [TO_W-1:0]     cnt_q;
  logic                fail_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [ID_W-1:0]     pick_id;
  logic                pick_vld;
  logic [N_REQ-1:0]         rw_sh;
  logic [ADDR_W*N_REQ-1:0]  addr_sh;
  logic [DATA_W*N_REQ-1:0]  data_sh;
  logic                to_hit, drive, resp;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .id    (pick_id),
    .valid (pick_vld)
  );

  assign rw_sh   = REQ_RW >> pick_id;
  assign addr_sh = REQ_ADDR >> (ADDR_W * int'(pick_id));
  assign data_sh = REQ_DATA >> (DATA_W * int'(pick_id));

  always_comb begin
    txn_sel      = '0;
    txn_sel.id   = pick_id;
    txn_sel.rw   = rw_sh[0];
    txn_sel.addr = addr_sh[ADDR_W-1:0];
    txn_sel.data = data_sh[DATA_W-1:0];
  end

  // Counter reaches TIMEOUT on the cycle it would tick past the limit.
  assign to_hit = (cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (ULPI_READY && pick_vld) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (ULPI_REG_FAIL || ULPI_REG_DONE || to_hit)
                  state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state   <= ST_IDLE;
      txn_q   <= '0;
      ptr_q   <= ID_W'(N_REQ - 1);
      cnt_q   <= '0;
      fail_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        ST_IDLE: if (state_nxt == ST_ISSUE) txn_q <= txn_sel;
        ST_ISSUE: begin
          cnt_q   <= '0;
          fail_q  <= 1'b0;
          rdata_q <= '0;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (ULPI_REG_FAIL) fail_q <= 1'b1;
          else if (ULPI_REG_DONE) begin
            if (!txn_q.rw) rdata_q <= ULPI_REG_DATA_O;
          end else if (to_hit) fail_q <= 1'b1;
        end
        ST_RESP: ptr_q <= txn_q.id;
        default: ;
      endcase
    end
  end

  assign drive = (state == ST_ISSUE) || (state == ST_WAIT);
  assign resp  = (state == ST_RESP);

  assign BUSY            = (state != ST_IDLE);
  assign GRANT_ID        = txn_q.id;
  assign ULPI_REG_EN     = (state == ST_ISSUE);
  assign ULPI_REG_RW     = drive & txn_q.rw;
  assign ULPI_REG_ADDR   = drive ? txn_q.addr : '0;
  assign ULPI_REG_DATA_I = drive ? txn_q.data : '0;
  assign ACK             = resp ? (N_REQ'(1) << txn_q.id) : '0;
  assign ACK_FAIL        = resp & fail_q;
  assign ACK_DATA        = resp ? rdata_q : '0;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Self-checking bench for ulpi_reg_arbiter: directed table,
// reset/readiness corners and a randomized transaction model.
module tb_ulpi_reg_arbiter;
  import usb_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  rwv = '0;
  logic [23:0] addrv = '0;
  logic [31:0] datav = '0;
  logic        rdy = 1'b0;
  logic [7:0]  dout = '0;
  logic        done = 1'b0;
  logic        fail = 1'b0;

  logic [3:0]  ack;
  logic        ack_fail;
  logic [7:0]  ack_data;
  logic        busy;
  logic [2:0]  gid;
  logic        en;
  logic        rw;
  logic [5:0]  addr;
  logic [7:0]  di;

  int checks = 0;
  int errors = 0;
  int mptr = N - 1;
  int o_id, o_fail, o_data, o_lat, en_lat;

  always #8 clk = ~clk;

  ulpi_reg_arbiter #(.N_REQ(N), .TIMEOUT(TO), .TO_W(8)) dut (
    .CLK_60M         (clk),
    .NRST_A_USB      (rst_n),
    .REQ             (req),
    .REQ_RW          (rwv),
    .REQ_ADDR        (addrv),
    .REQ_DATA        (datav),
    .ACK             (ack),
    .ACK_FAIL        (ack_fail),
    .ACK_DATA        (ack_data),
    .BUSY            (busy),
    .GRANT_ID        (gid),
    .ULPI_READY      (rdy),
    .ULPI_REG_EN     (en),
    .ULPI_REG_RW     (rw),
    .ULPI_REG_ADDR   (addr),
    .ULPI_REG_DATA_I (di),
    .ULPI_REG_DATA_O (dout),
    .ULPI_REG_DONE   (done),
    .ULPI_REG_FAIL   (fail)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Winner = first requester after the last granted one, wrapping.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 1; i <= N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // kind: 0 DONE, 1 FAIL, 2 DONE+FAIL, 3 silent PHY
  task automatic do_txn(input int kind, input int d, input logic [7:0] dv,
                        input bit drop, input bit rdy_w);
    int eid, n, k, ek;
    bit seen, efail;
    logic r_rw;
    logic [5:0] r_a;
    logic [7:0] r_d, ed;
    o_id = -1; o_fail = -1; o_data = -1; o_lat = -1;
    eid = pick(req, mptr);
    if (eid < 0) begin
      chk("pick_valid", 0, 1);
      return;
    end
    r_rw = rwv[eid];
    r_a  = addrv[eid*6 +: 6];
    r_d  = datav[eid*8 +: 8];
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (en !== 1'b1 && n < 8);
    en_lat = n;
    chk("en_seen", en, 1);
    if (en !== 1'b1) return;
    chk("grant_id", gid, eid);
    chk("reg_rw", rw, r_rw);
    chk("reg_addr", addr, r_a);
    chk("reg_data", di, r_d);
    if (drop) req[eid] = 1'b0;
    efail = !(kind == 0 && d <= TO);
    ek = (kind != 3 && d <= TO) ? d + 1 : TO + 1;
    ed = (!efail && !r_rw) ? dv : 8'h00;
    k = 0;
    seen = 0;
    while (!seen && k < TO + 4) begin
      @(negedge clk);
      k++;
      done = 1'b0;
      fail = 1'b0;
      dout = 8'($urandom);
      if (k == 1) begin
        chk("en_pulse", en, 0);
        chk("addr_hold", addr, r_a);
        rdy = rdy_w;
      end
      if (ack != 4'b0) seen = 1;
      else if (kind != 3 && k == d) begin
        done = (kind != 1);
        fail = (kind != 0);
        dout = dv;
      end
    end
    rdy = 1'b1;
    chk("ack_seen", seen, 1);
    if (!seen) return;
    for (int i = 0; i < N; i++) if (ack[i]) o_id = i;
    o_fail = int'(ack_fail);
    o_data = int'(ack_data);
    o_lat  = k;
    chk("ack_lat", k, ek);
    chk("ack_vec", ack, 1 << eid);
    chk("ack_fail", ack_fail, efail);
    chk("ack_data", ack_data, ed);
    chk("busy_resp", busy, 1);
    chk("addr_resp", addr, 0);
    mptr = eid;
  endtask

  typedef struct {
    logic [3:0] mask;
    logic       rw;
    logic [5:0] a;
    logic [7:0] wd;
    int         kind;
    int         d;
    logic [7:0] dv;
    bit         drop;
    int         eid;
    int         efail;
    int         edata;
    int         elat;
  } vec_t;

  vec_t tbl[12];

  initial begin
    bit bad;
    logic [3:0] newb;
    int kind, r;

    tbl[0]  = '{4'b1011, 1'b1, ADDR_SCRATCH, 8'hA5, 0, 1, 8'h00, 0, 0, 0, 0, 2};
    tbl[1]  = '{4'b1011, 1'b1, ADDR_SCRATCH, 8'hA5, 0, 1, 8'h00, 0, 1, 0, 0, 2};
    tbl[2]  = '{4'b1011, 1'b1, ADDR_SCRATCH, 8'hA5, 0, 1, 8'h00, 0, 3, 0, 0, 2};
    tbl[3]  = '{4'b1011, 1'b1, ADDR_SCRATCH, 8'hA5, 0, 1, 8'h00, 0, 0, 0, 0, 2};
    tbl[4]  = '{4'b1011, 1'b1, ADDR_SCRATCH, 8'hA5, 0, 1, 8'h00, 0, 1, 0, 0, 2};
    tbl[5]  = '{4'b1011, 1'b1, ADDR_SCRATCH, 8'hA5, 0, 1, 8'h00, 0, 3, 0, 0, 2};
    tbl[6]  = '{4'b0001, 1'b1, ADDR_OTG_CTRL, 8'h00, 0, 3, 8'h00, 0, 0, 0, 0, 4};
    tbl[7]  = '{4'b0100, 1'b0, ADDR_SCRATCH, 8'h00, 0, 2, 8'h55, 0, 2, 0, 'h55, 3};
    tbl[8]  = '{4'b0010, 1'b0, ADDR_FUN_CTRL, 8'h00, 1, 2, 8'h77, 0, 1, 1, 0, 3};
    tbl[9]  = '{4'b1000, 1'b0, ADDR_OTG_CTRL, 8'h00, 2, 1, 8'h33, 0, 3, 1, 0, 2};
    tbl[10] = '{4'b0001, 1'b0, ADDR_SCRATCH, 8'h00, 3, 0, 8'h99, 0, 0, 1, 0, 17};
    tbl[11] = '{4'b0100, 1'b1, ADDR_FUN_CTRL, 8'h3C, 0, 4, 8'h00, 1, 2, 0, 0, 5};

    #3;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", en, 0);
    chk("rst_gid", gid, 0);
    chk("rst_addr", {ack_fail, ack_data, rw, addr, di}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Requests must be ignored while the ULPI block is not ready.
    req = 4'b0001;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (en !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    chk("no_grant_unready", bad, 0);
    rdy = 1'b1;

    foreach (tbl[i]) begin
      req   = tbl[i].mask;
      rwv   = {4{tbl[i].rw}};
      addrv = {4{tbl[i].a}};
      datav = {4{tbl[i].wd}};
      do_txn(tbl[i].kind, tbl[i].d, tbl[i].dv, tbl[i].drop, 1'b1);
      chk("tbl_en_lat", en_lat, (i == 0) ? 1 : 2);
      chk("tbl_id", o_id, tbl[i].eid);
      chk("tbl_fail", o_fail, tbl[i].efail);
      chk("tbl_data", o_data, tbl[i].edata);
      chk("tbl_lat", o_lat, tbl[i].elat);
    end
    req = '0;

    // Reset in the middle of a transaction: no ACK, back to req0 first.
    req = 4'b0100;
    r = 0;
    do begin
      @(negedge clk);
      r++;
    end while (en !== 1'b1 && r < 8);
    chk("rst_txn_en", en, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out", {en, ack_fail, ack_data, rw, addr, di, gid}, 0);
    req = 4'b1111;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack !== 4'b0 || busy !== 1'b0) bad = 1;
    end
    chk("held_rst_quiet", bad, 0);
    rst_n = 1'b1;
    mptr = N - 1;
    do_txn(0, 2, 8'h00, 0, 1'b1);
    chk("post_rst_id", o_id, 0);
    req = '0;

    for (int t = 0; t < 40; t++) begin
      newb = 4'($urandom_range(0, 15)) & ~req;
      if ((req | newb) == 4'b0) newb = 4'b0001 << $urandom_range(0, 3);
      for (int i = 0; i < N; i++) begin
        if (newb[i]) begin
          rwv[i]          = 1'($urandom_range(0, 1));
          addrv[i*6 +: 6] = 6'($urandom);
          datav[i*8 +: 8] = 8'($urandom);
        end
      end
      req = req | newb;
      r = $urandom_range(0, 7);
      kind = (r < 4) ? 0 : (r < 6) ? 1 : (r == 6) ? 2 : 3;
      do_txn(kind, $urandom_range(1, 5), 8'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      if (o_id >= 0 && $urandom_range(0, 3) != 0) req[o_id] = 1'b0;
    end
    req = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
